// File: rtl/datapath_controller_if.sv
// datapath_controller_if
//   Bundles the controller <-> datapath signals.
//   master : the controller (drives control, PC, IR, debug state)
//   slave  : the datapath / RAM side (drives RAM read data, ALU result, zero flag)
//   ramReadData        block RAM read data (one cycle after address)
//   aluOutput/zeroFlag ALU result and its zero indication
//   instruction        instruction register
//   programCounter     program counter
//   *WriteEnable       one-cycle write strobes
//   *SelectionLine     datapath mux selects
//   decoderRamWriteAddress  destination register address from IR[11:8]
//   halted / state     status and debug
interface datapath_controller_if;
  logic [15:0] ramReadData;
  logic [15:0] aluOutput;
  logic        zeroFlag;
  logic [15:0] instruction;
  logic [15:0] programCounter;
  logic        blockRamWriteEnable;
  logic        registerFileWriteEnable;
  logic [1:0]  integerTypeSelectionLine;
  logic        reg2OrImmediateSelectionLine;
  logic        pcOrRegisterSelectionLine;
  logic        addressFromRegOrDecoderSelectionLine;
  logic        writeBackToRegRamOrALUSelectionLine;
  logic        pcOrAluOutputRamReadSelectionLine;
  logic [15:0] decoderRamWriteAddress;
  logic        halted;
  logic [2:0]  state;

  modport master (
    input  ramReadData, aluOutput, zeroFlag,
    output instruction, programCounter,
    output blockRamWriteEnable, registerFileWriteEnable,
    output integerTypeSelectionLine, reg2OrImmediateSelectionLine,
    output pcOrRegisterSelectionLine, addressFromRegOrDecoderSelectionLine,
    output writeBackToRegRamOrALUSelectionLine, pcOrAluOutputRamReadSelectionLine,
    output decoderRamWriteAddress, halted, state
  );

  modport slave (
    output ramReadData, aluOutput, zeroFlag,
    input  instruction, programCounter,
    input  blockRamWriteEnable, registerFileWriteEnable,
    input  integerTypeSelectionLine, reg2OrImmediateSelectionLine,
    input  pcOrRegisterSelectionLine, addressFromRegOrDecoderSelectionLine,
    input  writeBackToRegRamOrALUSelectionLine, pcOrAluOutputRamReadSelectionLine,
    input  decoderRamWriteAddress, halted, state
  );
endinterface

// File: rtl/datapath_controller.sv
// datapath_controller
//   Multi-cycle FSM sequencing a 16-bit datapath:
//   FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] -> FETCH, plus HALT.
//   Owns the program counter and instruction register; all control outputs
//   are decoded combinationally from the current state and the IR.
// Ports
//   clock  system clock, rising edge
//   reset  synchronous, active-high
//   bus    datapath_controller_if.master (see interface for signal list)
module datapath_controller (
  input  logic                  clock,
  input  logic                  reset,
  datapath_controller_if.master bus
);

  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] EXECUTE   = 3'd2;
  localparam logic [2:0] MEMORY    = 3'd3;
  localparam logic [2:0] WRITEBACK = 3'd4;
  localparam logic [2:0] HALT      = 3'd5;

  localparam logic [3:0] OP_R     = 4'h0;
  localparam logic [3:0] OP_ISGN  = 4'h1;
  localparam logic [3:0] OP_IZERO = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_JUMP  = 4'h5;
  localparam logic [3:0] OP_BEQZ  = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  logic [2:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [3:0]  w_op;

  assign w_op = r_ir[15:12];

  // State, PC and IR update
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= 16'h0000;
      r_ir    <= 16'h0000;
    end else begin
      case (r_state)
        FETCH: r_state <= DECODE;
        DECODE: begin
          r_ir    <= bus.ramReadData;
          r_pc    <= r_pc + 16'd1;
          // Opcode is checked on the incoming word, so HALT skips EXECUTE.
          r_state <= (bus.ramReadData[15:12] == OP_HALT) ? HALT : EXECUTE;
        end
        EXECUTE: begin
          case (w_op)
            OP_R, OP_ISGN, OP_IZERO: r_state <= WRITEBACK;
            OP_LOAD, OP_STORE:       r_state <= MEMORY;
            default:                 r_state <= FETCH;
          endcase
          if ((w_op == OP_JUMP) || ((w_op == OP_BEQZ) && bus.zeroFlag))
            r_pc <= bus.aluOutput;
        end
        MEMORY:    r_state <= (w_op == OP_LOAD) ? WRITEBACK : FETCH;
        WRITEBACK: r_state <= FETCH;
        HALT:      r_state <= HALT;
        default:   r_state <= FETCH;
      endcase
    end
  end

  // Control decode
  always_comb begin
    bus.blockRamWriteEnable                  = 1'b0;
    bus.registerFileWriteEnable              = 1'b0;
    bus.integerTypeSelectionLine             = 2'b00;
    bus.reg2OrImmediateSelectionLine         = 1'b0;
    bus.pcOrRegisterSelectionLine            = 1'b0;
    bus.addressFromRegOrDecoderSelectionLine = 1'b0;
    bus.writeBackToRegRamOrALUSelectionLine  = 1'b0;
    bus.pcOrAluOutputRamReadSelectionLine    = 1'b0;
    bus.halted                               = 1'b0;

    // Operand selects are held for the whole back half of the instruction.
    if ((r_state == EXECUTE) || (r_state == MEMORY) || (r_state == WRITEBACK)) begin
      case (w_op)
        OP_R: bus.pcOrRegisterSelectionLine = 1'b1;
        OP_ISGN, OP_LOAD, OP_STORE, OP_JUMP, OP_BEQZ: begin
          bus.pcOrRegisterSelectionLine    = 1'b1;
          bus.reg2OrImmediateSelectionLine = 1'b1;
          bus.integerTypeSelectionLine     = 2'b01;
        end
        OP_IZERO: begin
          bus.pcOrRegisterSelectionLine    = 1'b1;
          bus.reg2OrImmediateSelectionLine = 1'b1;
          bus.integerTypeSelectionLine     = 2'b10;
        end
        default: ;
      endcase
    end

    // Strobes are masked by reset: the write that would land on the reset
    // edge is abandoned rather than committed.
    case (r_state)
      FETCH: bus.pcOrAluOutputRamReadSelectionLine = 1'b1;
      MEMORY: begin
        if (w_op == OP_STORE) begin
          bus.blockRamWriteEnable                  = ~reset;
          bus.addressFromRegOrDecoderSelectionLine = 1'b0;
        end
      end
      WRITEBACK: begin
        bus.registerFileWriteEnable              = ~reset;
        bus.addressFromRegOrDecoderSelectionLine = 1'b1;
        bus.writeBackToRegRamOrALUSelectionLine  = (w_op != OP_LOAD);
      end
      HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.instruction            = r_ir;
  assign bus.programCounter         = r_pc;
  assign bus.state                  = r_state;
  assign bus.decoderRamWriteAddress = {12'h000, r_ir[11:8]};

endmodule

// File: tb/tb_datapath_controller.sv
module tb_datapath_controller;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  datapath_controller_if bus ();

  datapath_controller dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        rf;
    logic        bw;
    logic        h;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [15:0] pc, input logic [15:0] ir,
                      input logic rf, input logic bw, input logic h);
    exp_t e;
    e.st = st; e.pc = pc; e.ir = ir; e.rf = rf; e.bw = bw; e.h = h;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles, comparing each cycle against the next queued expectation.
  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      step();
      total++;
      assert (q.size() != 0)
      else begin
        bad++;
        $error("FAIL scoreboard_empty observed=0 expected=entry");
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("state",  {13'h0, bus.state}, {13'h0, e.st});
        chk("pc",     bus.programCounter, e.pc);
        chk("ir",     bus.instruction, e.ir);
        chk("rf_we",  {15'h0, bus.registerFileWriteEnable}, {15'h0, e.rf});
        chk("ram_we", {15'h0, bus.blockRamWriteEnable}, {15'h0, e.bw});
        chk("halted", {15'h0, bus.halted}, {15'h0, e.h});
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.ramReadData = 16'h0000;
    bus.aluOutput   = 16'h0000;
    bus.zeroFlag    = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_state", {13'h0, bus.state}, 16'h0000);
    chk("rst_pc", bus.programCounter, 16'h0000);
    chk("rst_ir", bus.instruction, 16'h0000);
    chk("rst_halted", {15'h0, bus.halted}, 16'h0000);
    rst = 1'b0;
    chk("fetch_ramsel", {15'h0, bus.pcOrAluOutputRamReadSelectionLine}, 16'h0001);

    // R-type 0123 at address 0
    bus.ramReadData = 16'h0123;
    push(3'd1, 16'h0000, 16'h0000, 0, 0, 0);
    push(3'd2, 16'h0001, 16'h0123, 0, 0, 0);
    push(3'd4, 16'h0001, 16'h0123, 1, 0, 0);
    push(3'd0, 16'h0001, 16'h0123, 0, 0, 0);
    run(2);
    chk("r_pcsel", {15'h0, bus.pcOrRegisterSelectionLine}, 16'h0001);
    chk("r_immsel", {15'h0, bus.reg2OrImmediateSelectionLine}, 16'h0000);
    chk("r_inttype", {14'h0, bus.integerTypeSelectionLine}, 16'h0000);
    run(1);
    chk("r_wbsel", {15'h0, bus.writeBackToRegRamOrALUSelectionLine}, 16'h0001);
    chk("r_addrsel", {15'h0, bus.addressFromRegOrDecoderSelectionLine}, 16'h0001);
    run(1);

    // LOAD 3205
    bus.ramReadData = 16'h3205;
    push(3'd1, 16'h0001, 16'h0123, 0, 0, 0);
    push(3'd2, 16'h0002, 16'h3205, 0, 0, 0);
    push(3'd3, 16'h0002, 16'h3205, 0, 0, 0);
    push(3'd4, 16'h0002, 16'h3205, 1, 0, 0);
    push(3'd0, 16'h0002, 16'h3205, 0, 0, 0);
    run(3);
    chk("ld_ramsel", {15'h0, bus.pcOrAluOutputRamReadSelectionLine}, 16'h0000);
    chk("ld_immsel", {15'h0, bus.reg2OrImmediateSelectionLine}, 16'h0001);
    chk("ld_inttype", {14'h0, bus.integerTypeSelectionLine}, 16'h0001);
    run(1);
    chk("ld_wbsel", {15'h0, bus.writeBackToRegRamOrALUSelectionLine}, 16'h0000);
    chk("ld_dstaddr", bus.decoderRamWriteAddress, 16'h0002);
    run(1);

    // STORE 4107
    bus.ramReadData = 16'h4107;
    push(3'd1, 16'h0002, 16'h3205, 0, 0, 0);
    push(3'd2, 16'h0003, 16'h4107, 0, 0, 0);
    push(3'd3, 16'h0003, 16'h4107, 0, 1, 0);
    push(3'd0, 16'h0003, 16'h4107, 0, 0, 0);
    run(3);
    chk("st_addrsel", {15'h0, bus.addressFromRegOrDecoderSelectionLine}, 16'h0000);
    run(1);

    // I-zero 2ABC
    bus.ramReadData = 16'h2ABC;
    push(3'd1, 16'h0003, 16'h4107, 0, 0, 0);
    push(3'd2, 16'h0004, 16'h2ABC, 0, 0, 0);
    push(3'd4, 16'h0004, 16'h2ABC, 1, 0, 0);
    push(3'd0, 16'h0004, 16'h2ABC, 0, 0, 0);
    run(2);
    chk("iz_inttype", {14'h0, bus.integerTypeSelectionLine}, 16'h0002);
    run(1);
    chk("iz_inttype_wb", {14'h0, bus.integerTypeSelectionLine}, 16'h0002);
    chk("iz_dstaddr", bus.decoderRamWriteAddress, 16'h000A);
    run(1);

    // BEQZ taken
    bus.ramReadData = 16'h6000;
    bus.aluOutput   = 16'h0040;
    bus.zeroFlag    = 1'b1;
    push(3'd1, 16'h0004, 16'h2ABC, 0, 0, 0);
    push(3'd2, 16'h0005, 16'h6000, 0, 0, 0);
    push(3'd0, 16'h0040, 16'h6000, 0, 0, 0);
    run(3);

    // BEQZ not taken
    bus.zeroFlag = 1'b0;
    push(3'd1, 16'h0040, 16'h6000, 0, 0, 0);
    push(3'd2, 16'h0041, 16'h6000, 0, 0, 0);
    push(3'd0, 16'h0041, 16'h6000, 0, 0, 0);
    run(3);

    // JUMP to FFFF
    bus.ramReadData = 16'h5000;
    bus.aluOutput   = 16'hFFFF;
    push(3'd1, 16'h0041, 16'h6000, 0, 0, 0);
    push(3'd2, 16'h0042, 16'h5000, 0, 0, 0);
    push(3'd0, 16'hFFFF, 16'h5000, 0, 0, 0);
    run(3);

    // NOP at FFFF: PC wraps
    bus.ramReadData = 16'h7000;
    push(3'd1, 16'hFFFF, 16'h5000, 0, 0, 0);
    push(3'd2, 16'h0000, 16'h7000, 0, 0, 0);
    push(3'd0, 16'h0000, 16'h7000, 0, 0, 0);
    run(3);

    // STORE interrupted by reset in MEMORY
    bus.ramReadData = 16'h4107;
    push(3'd1, 16'h0000, 16'h7000, 0, 0, 0);
    push(3'd2, 16'h0001, 16'h4107, 0, 0, 0);
    run(2);
    step();
    chk("rs_state_mem", {13'h0, bus.state}, 16'h0003);
    rst = 1'b1;
    #1;
    chk("rs_we_masked", {15'h0, bus.blockRamWriteEnable}, 16'h0000);
    push(3'd0, 16'h0000, 16'h0000, 0, 0, 0);
    run(1);
    rst = 1'b0;

    // HALT
    bus.ramReadData = 16'hF000;
    push(3'd1, 16'h0000, 16'h0000, 0, 0, 0);
    push(3'd5, 16'h0001, 16'hF000, 0, 0, 1);
    push(3'd5, 16'h0001, 16'hF000, 0, 0, 1);
    push(3'd5, 16'h0001, 16'hF000, 0, 0, 1);
    push(3'd5, 16'h0001, 16'hF000, 0, 0, 1);
    run(2);
    bus.ramReadData = 16'h0123;
    run(3);

    // Reset leaves HALT
    rst = 1'b1;
    push(3'd0, 16'h0000, 16'h0000, 0, 0, 0);
    run(1);
    rst = 1'b0;
    chk("post_halt_ramsel", {15'h0, bus.pcOrAluOutputRamReadSelectionLine}, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath_controller.md
DATAPATH_CONTROLLER -- requirements
Module: datapath_controller

Interface
REQ-001 The module SHALL have exactly one clock and one reset. `reset` SHALL be synchronous and active-high.
REQ-002 clock  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ramReadData  in  16  block RAM read data, valid one cycle after its read address is presented.
REQ-005 aluOutput  in  16  datapath ALU result.
REQ-006 zeroFlag  in  1  high when aluOutput == 16'h0000.
REQ-007 instruction  out  16  instruction register contents.
REQ-008 programCounter  out  16  program counter register.
REQ-009 blockRamWriteEnable and registerFileWriteEnable  out  1 each  write strobes, one cycle wide.
REQ-010 integerTypeSelectionLine  out  2  immediate select: 00 raw, 01 sign-extended, 10 zero-extended, 11 constant 1.
REQ-011 The following 1-bit outputs SHALL use the listed encodings:
- reg2OrImmediateSelectionLine: 0 = reg2, 1 = immediate.
- pcOrRegisterSelectionLine: 0 = PC, 1 = reg1.
- addressFromRegOrDecoderSelectionLine: 0 = reg2, 1 = decoder.
- writeBackToRegRamOrALUSelectionLine: 0 = RAM, 1 = ALU.
- pcOrAluOutputRamReadSelectionLine: 0 = ALU, 1 = PC.
REQ-012 decoderRamWriteAddress  out  16  destination register address, equal to {12'h000, instruction[11:8]}.
REQ-013 halted  out  1  high while in HALT.
REQ-014 state  out  3  current state, for debug.

Function
REQ-015 The module SHALL implement these states: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5. Codes 6 and 7 SHALL go to FETCH on the next edge.
REQ-016 Outputs SHALL be combinational from state and the instruction register. Any control not named for a state SHALL be 0.
REQ-017 FETCH: pcOrAluOutputRamReadSelectionLine=1. Next state SHALL be DECODE.
REQ-018 DECODE: the instruction register SHALL latch ramReadData. PC SHALL become PC+1 mod 2^16 (16'hFFFF wraps to 16'h0000). Next state SHALL be EXECUTE, or HALT if ramReadData[15:12]==4'hF.
REQ-019 Opcode is instruction[15:12].
- 0 = R-type: pcOrRegister=1, reg2OrImm=0.
- 1 = I-signed: pcOrRegister=1, reg2OrImm=1, intType=01.
- 2 = I-zero: as I-signed but intType=10.
- 3 = LOAD and 4 = STORE: as I-signed.
- 5 = JUMP and 6 = BEQZ: as I-signed.
- 7..E are NOPs.
These selects SHALL be held in EXECUTE, MEMORY and WRITEBACK.
REQ-020 EXECUTE next state SHALL be:
- WRITEBACK for opcodes 0, 1 and 2.
- MEMORY for opcodes 3 and 4.
- FETCH for all others.
REQ-021 At the end of EXECUTE, JUMP SHALL load PC from aluOutput. BEQZ SHALL do the same only if zeroFlag==1, otherwise PC is unchanged.
REQ-022 MEMORY, LOAD: pcOrAluOutputRamReadSelectionLine=0, then next state WRITEBACK.
REQ-023 MEMORY, STORE: blockRamWriteEnable=1 and addressFromRegOrDecoderSelectionLine=0 for exactly one cycle, then next state FETCH.
REQ-024 WRITEBACK: registerFileWriteEnable=1 and addressFromRegOrDecoderSelectionLine=1. writeBackToRegRamOrALUSelectionLine SHALL be 0 for LOAD and 1 otherwise. Next state SHALL be FETCH.
REQ-025 Instruction latency SHALL be:
- R/I-type: 4 cycles.
- LOAD: 5 cycles.
- STORE: 4 cycles.
- JUMP, BEQZ and NOP: 3 cycles.
- HALT: 2 cycles, then remain in HALT.
REQ-026 In HALT, halted=1, all enables are 0, and PC and the instruction register SHALL hold. Only reset leaves HALT.
REQ-027 A write strobe SHALL never be asserted in FETCH, DECODE or HALT.

Reset
REQ-028 A reset asserted in any state SHALL, on the next edge, force state=FETCH, programCounter=16'h0000, instruction=16'h0000 and halted=0. Any in-flight write SHALL be abandoned: no strobe is asserted in the cycle after the reset edge.
REQ-029 Reset SHALL take priority over every transition, including HALT.

Verification
REQ-030 Reset, then R-type 16'h0123 at address 0 -> states 0,1,2,4,0. registerFileWriteEnable is high only in cycle 4, with writeBackToRegRamOrALUSelectionLine=1. PC=1.
REQ-031 LOAD 16'h3205 -> states 0,1,2,3,4. In MEMORY, pcOrAluOutputRamReadSelectionLine=0. In WRITEBACK, writeBackToRegRamOrALUSelectionLine=0 and decoderRamWriteAddress=16'h0002.
REQ-032 STORE 16'h4107 -> blockRamWriteEnable high for exactly one cycle, in MEMORY, with addressFromRegOrDecoderSelectionLine=0. registerFileWriteEnable is never high.
REQ-033 BEQZ with aluOutput=16'h0040: zeroFlag=1 -> PC=16'h0040 after EXECUTE. zeroFlag=0 -> PC unchanged.
REQ-034 PC=16'hFFFF fetching a NOP -> PC=16'h0000 after DECODE. HALT 16'hF000 -> halted=1 indefinitely.
REQ-035 Reset asserted during MEMORY of a STORE -> no blockRamWriteEnable pulse, state=0 and PC=0 on the next edge.
